pulse_event_queue: RTL and testbench
====================================

PULSE_EVENT_QUEUE -- requirements
Module: pulse_event_queue

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the pending-event counter width (maximum pending = 2^CNT_W-1).
REQ-002 The block SHALL have parameter GAP_CYC, default 1, setting the idle clk_fast cycles between synchro_busy low and the next pulse_out (range 0..15).
REQ-003 clk_fast  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 event_in  input  1  single-cycle event request; each high cycle is one event.
REQ-006 synchro_busy  input  1  busy from the downstream fast-to-slow pulse synchronizer; high while a transfer is in flight.
REQ-007 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 pulse_out  output  1  one-cycle pulse to the synchronizer pulse input.
REQ-009 pending  output  CNT_W  number of events accepted but not yet issued.
REQ-010 overflow  output  1  sticky: an event was lost because the counter was saturated.
REQ-011 q_idle  output  1  high when pending==0 and the FSM is in IDLE.

Function
REQ-012 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, GAP.
REQ-013 IDLE->ISSUE when pending!=0 and synchro_busy==0; otherwise remain in IDLE.
REQ-014 In ISSUE, pulse_out SHALL be high for exactly one cycle, pending SHALL decrement by 1, and the next state SHALL be WAIT_BUSY.
REQ-015 pulse_out SHALL be a registered output, high only while the FSM is in ISSUE.
REQ-016 In WAIT_BUSY, the block SHALL wait for synchro_busy==0; it SHALL then go to GAP if GAP_CYC>0, else to IDLE.
REQ-017 GAP SHALL count GAP_CYC cycles, then go to IDLE.
REQ-018 Issue latency: with pending==0, synchro_busy==0 and FSM in IDLE, event_in at cycle N SHALL make pulse_out high at cycle N+2.
REQ-019 event_in SHALL increment pending; the ISSUE decrement and event_in in the same cycle SHALL leave pending unchanged.
REQ-020 When pending==2^CNT_W-1, an event_in without a same-cycle decrement SHALL be dropped, pending SHALL hold, and overflow SHALL be set.
REQ-021 pending SHALL never wrap, and SHALL never decrement below 0.
REQ-022 clr_ovf SHALL clear overflow; if clr_ovf and a new overflow occur in the same cycle, overflow SHALL be set (set wins).
REQ-023 If synchro_busy is high in IDLE, no pulse SHALL issue; events SHALL keep accumulating.

Reset
REQ-024 On reset assertion: pulse_out=0, pending=0, overflow=0, q_idle=1, FSM=IDLE, gap counter=0, all asynchronously.
REQ-025 Reset during ISSUE SHALL drop pulse_out in the same cycle; the in-flight event SHALL be discarded.
REQ-026 The first pulse_out after reset deassertion SHALL be no earlier than the second rising clk_fast edge.

Configuration
REQ-027 Macro PULSE_EVENT_QUEUE_DROP_CNT_EN SHALL add output drop_cnt (8 bits), which counts dropped events, saturates at 255, and is cleared by reset and by clr_ovf.
REQ-028 Without PULSE_EVENT_QUEUE_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Single event: reset, then event_in high 1 cycle with busy=0 -> pulse_out high exactly 1 cycle 2 cycles later; pending 1->0; q_idle returns to 1.
REQ-030 Back-to-back: 3 consecutive event_in cycles; busy high 4 cycles after each pulse; GAP_CYC=1 -> 3 pulses total, each issued only after busy low plus 1 gap cycle, never while busy=1.
REQ-031 Saturation: CNT_W=4, busy held high, 17 events -> pending=15, overflow=1 (drop_cnt=2 when the macro is enabled); clr_ovf -> overflow=0.
REQ-032 Simultaneous events: event_in coincident with the ISSUE cycle at pending=15 -> pending stays 15, overflow stays 0.
REQ-033 Async reset mid-ISSUE: reset asserted between edges while pulse_out=1 -> pulse_out=0 and pending=0 immediately, without waiting for a clock edge.
REQ-034 Busy at idle: busy=1 with pending=2 for 10 cycles -> no pulse_out; busy falls -> a pulse follows within 1 cycle.

Source files
------------

// File: rtl/pulse_event_queue.sv
// pulse_event_queue: counts single-cycle event requests and issues them one at a
// time as registered pulses to a downstream fast-to-slow pulse synchronizer.
// Each pulse is held off while the synchronizer is busy, followed by a GAP_CYC
// idle gap.
// Optional macro PULSE_EVENT_QUEUE_DROP_CNT_EN adds an 8-bit saturating
// count of dropped events (drop_cnt).
module pulse_event_queue #(
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic             clk_fast,
    input  logic             reset,
    input  logic             event_in,
    input  logic             synchro_busy,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             q_idle
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             pulse_out_q, pulse_out_d;
    logic             inc, dec, sat, drop;

    // Counter control: the decrement is taken on the edge that ends the ISSUE cycle
    always_comb begin
        dec  = (state_q == ISSUE) && (pending_q != '0);
        inc  = event_in;
        sat  = (pending_q == CNT_MAX);
        drop = inc && sat && !dec;
    end

    // Pending count and sticky overflow (a new overflow beats clr_ovf)
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (inc && !dec && !sat) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (dec && !inc) begin
            pending_d = pending_q - CNT_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Next-state logic; pulse_out is registered so it tracks the ISSUE state exactly
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q != '0 && !synchro_busy) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!synchro_busy) begin
                    gap_d = '0;
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
        pulse_out_d = (state_d == ISSUE);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            pulse_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            pulse_out_q <= pulse_out_d;
        end
    end

`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop in the clearing cycle restarts the count at 1
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign pulse_out = pulse_out_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign q_idle    = (pending_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed testbench for pulse_event_queue (CNT_W=4, GAP_CYC=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pulse_event_queue;

    logic       clk_fast = 1'b0;
    logic       reset;
    logic       event_in;
    logic       synchro_busy;
    logic       clr_ovf;
    logic       pulse_out;
    logic [3:0] pending;
    logic       overflow;
    logic       q_idle;
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pulse_event_queue #(.CNT_W(4), .GAP_CYC(1)) dut (
        .clk_fast     (clk_fast),
        .reset        (reset),
        .event_in     (event_in),
        .synchro_busy (synchro_busy),
        .clr_ovf      (clr_ovf),
        .pulse_out    (pulse_out),
        .pending      (pending),
        .overflow     (overflow),
        .q_idle       (q_idle)
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_fast);
        @(negedge clk_fast);
    endtask

    initial begin
        int busy_cnt;
        reset        = 1'b1;
        event_in     = 1'b0;
        synchro_busy = 1'b0;
        clr_ovf      = 1'b0;
        @(negedge clk_fast);
        @(negedge clk_fast);

        // Reset state
        chk("rst_pulse",    32'(pulse_out), 32'd0);
        chk("rst_pending",  32'(pending),   32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_q_idle",   32'(q_idle),    32'd1);
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt),  32'd0);
`endif
        reset = 1'b0;
        step();

        // Single event: pulse two cycles after the event, for exactly one cycle
        event_in = 1'b1;
        step();
        event_in = 1'b0;
        chk("single_pend1",  32'(pending),   32'd1);
        chk("single_nopls",  32'(pulse_out), 32'd0);
        chk("single_busyq",  32'(q_idle),    32'd0);
        step();
        chk("single_pulse",  32'(pulse_out), 32'd1);
        chk("single_pend_i", 32'(pending),   32'd1);
        step();
        chk("single_pls_off", 32'(pulse_out), 32'd0);
        chk("single_pend0",   32'(pending),   32'd0);
        chk("single_wait_q",  32'(q_idle),    32'd0);
        step();
        step();
        chk("single_idle",   32'(q_idle),    32'd1);
        chk("single_nopls2", 32'(pulse_out), 32'd0);

        // Back-to-back: 3 events, synchronizer busy for 4 cycles after each pulse
        busy_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            chk($sformatf("b2b_pulse_%0d", i), 32'(pulse_out),
                (i == 2 || i == 9 || i == 16) ? 32'd1 : 32'd0);
            if (pulse_out) busy_cnt = 4;
            synchro_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            event_in = (i < 3);
            step();
        end
        chk("b2b_pend0", 32'(pending), 32'd0);
        chk("b2b_idle",  32'(q_idle),  32'd1);

        // Saturation with busy held high: 17 events, two dropped
        synchro_busy = 1'b1;
        event_in     = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk($sformatf("sat_nopulse_%0d", i), 32'(pulse_out), 32'd0);
        end
        event_in = 1'b0;
        chk("sat_pending",  32'(pending),  32'd15);
        chk("sat_overflow", 32'(overflow), 32'd1);
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        // New overflow in the clearing cycle keeps the flag set
        event_in = 1'b1;
        clr_ovf  = 1'b1;
        step();
        event_in = 1'b0;
        chk("setwin_ovf",  32'(overflow), 32'd1);
        chk("setwin_pend", 32'(pending),  32'd15);
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
        chk("setwin_drop", 32'(drop_cnt), 32'd1);
`endif
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf",      32'(overflow), 32'd0);
        chk("clr_pend",     32'(pending),  32'd15);
`ifdef PULSE_EVENT_QUEUE_DROP_CNT_EN
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Event coincident with the ISSUE cycle at full count
        synchro_busy = 1'b0;
        step();
        chk("sim_pulse", 32'(pulse_out), 32'd1);
        chk("sim_pend_i", 32'(pending),  32'd15);
        event_in = 1'b1;
        step();
        event_in = 1'b0;
        chk("sim_pend",  32'(pending),   32'd15);
        chk("sim_ovf",   32'(overflow),  32'd0);
        chk("sim_nopls", 32'(pulse_out), 32'd0);
        step();
        step();
        step();
        chk("gap_pulse", 32'(pulse_out), 32'd1);

        // Asynchronous reset while pulse_out is high, between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pulse",   32'(pulse_out), 32'd0);
        chk("arst_pending", 32'(pending),   32'd0);
        chk("arst_q_idle",  32'(q_idle),    32'd1);
        @(negedge clk_fast);
        reset = 1'b0;

        // Busy at idle: no pulse while busy, pulse right after busy falls
        synchro_busy = 1'b1;
        event_in     = 1'b1;
        step();
        step();
        event_in = 1'b0;
        chk("bidle_pend2", 32'(pending), 32'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bidle_nopulse_%0d", i), 32'(pulse_out), 32'd0);
        end
        synchro_busy = 1'b0;
        step();
        chk("bidle_pulse", 32'(pulse_out), 32'd1);
        step();
        chk("bidle_pend1", 32'(pending),   32'd1);
        chk("bidle_off",   32'(pulse_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
